// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if: run/halt/done control inputs and ck/stb step-phase outputs of the PDP-8 phase sequencer.
// sstep exists only when SEQ_SINGLESTEP_EN is defined.
interface phase_sequencer_if;
  logic run;
  logic halt;
  logic done;
`ifdef SEQ_SINGLESTEP_EN
  logic sstep;
`endif
  logic ck1, ck2, ck3, ck4, ck5, ck6;
  logic stb1, stb2, stb3, stb4, stb5, stb6;
  logic running;
  logic seqerr;
  logic [11:0] icount;
  modport master (
    input  run, halt, done,
`ifdef SEQ_SINGLESTEP_EN
    input  sstep,
`endif
    output ck1, ck2, ck3, ck4, ck5, ck6,
    output stb1, stb2, stb3, stb4, stb5, stb6,
    output running, seqerr, icount
  );
  modport slave (
    output run, halt, done,
`ifdef SEQ_SINGLESTEP_EN
    output sstep,
`endif
    input  ck1, ck2, ck3, ck4, ck5, ck6,
    input  stb1, stb2, stb3, stb4, stb5, stb6,
    input  running, seqerr, icount
  );
endinterface

// File: rtl/phase_sequencer.sv
// phase_sequencer: one-hot ck/stb step-phase generator with run/halt, sticky overrun and instruction count.
// Optional single-step mode under SEQ_SINGLESTEP_EN.
module phase_sequencer #(
  parameter int MAX_STEP  = 6,
  parameter bit RESET_RUN = 1'b0
) (
  input logic clk,
  input logic reset_n,
  phase_sequencer_if.master bus
);
  localparam logic [11:0] CK_MASK = 12'h555;
  localparam logic [11:0] CK1     = 12'h001;
  // bit 2(N-1) is ckN, bit 2N-1 is stbN; all-zero is HALTED
  logic [11:0] ph_q, ph_d;
  logic [11:0] cnt_q, cnt_d;
  logic        boot_q, hp_q, hp_d, err_q, err_d;
  logic        halted, accept, stop, last_stb;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph_q   <= '0;
      cnt_q  <= '0;
      boot_q <= 1'b1;
      hp_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      cnt_q  <= cnt_d;
      boot_q <= 1'b0;
      hp_q   <= hp_d;
      err_q  <= err_d;
    end
  end
  assign halted   = ph_q == '0;
  assign accept   = bus.done && |(ph_q & CK_MASK);
  assign last_stb = ph_q[2*MAX_STEP-1];
`ifdef SEQ_SINGLESTEP_EN
  assign stop = hp_q || bus.halt || bus.sstep;
`else
  assign stop = hp_q || bus.halt;
`endif
  always_comb begin
    ph_d  = ph_q;
    cnt_d = cnt_q;
    hp_d  = hp_q;
    err_d = err_q;
    if (halted) begin
      if ((boot_q && RESET_RUN) || (bus.run && !bus.halt)) begin
        ph_d  = CK1;
        hp_d  = 1'b0;
        err_d = 1'b0;
      end
    end else if (accept) begin
      cnt_d = cnt_q + 12'd1;
      ph_d  = stop ? '0 : CK1;
      hp_d  = 1'b0;
    end else if (last_stb) begin
      ph_d  = '0;
      hp_d  = 1'b0;
      err_d = 1'b1;
    end else begin
      ph_d = ph_q << 1;
      hp_d = hp_q || bus.halt;
    end
  end
  always_comb begin
    {bus.stb6, bus.ck6, bus.stb5, bus.ck5, bus.stb4, bus.ck4,
     bus.stb3, bus.ck3, bus.stb2, bus.ck2, bus.stb1, bus.ck1} = ph_q;
    bus.running = |ph_q;
    bus.seqerr  = err_q;
    bus.icount  = cnt_q;
  end
endmodule
